// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor core: opcode values,
// step encodings and the ALU operation select.
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_t;

endpackage

// File: rtl/multicycle_proc_core_alu.sv
// Combinational ALU for the multicycle core. The result is formed one bit
// wider than the datapath so the top bit serves as carry (or no-borrow for
// subtraction). Optional macro PROC_LOGIC_OPS_EN adds AND/XOR.
module proc_alu
    import proc_pkg::*;
#(
    parameter int REG_WIDTH = 16
) (
    input  logic [REG_WIDTH-1:0] a,
    input  logic [REG_WIDTH-1:0] b,
    input  alu_op_t              op,
    output logic [REG_WIDTH-1:0] result,
    output logic                 carry_out
);

    localparam logic [REG_WIDTH:0] ONE_W = {{REG_WIDTH{1'b0}}, 1'b1};

    logic [REG_WIDTH:0] wide;

    // Wide result; subtraction is a + ~b + 1 so bit REG_WIDTH means "no borrow"
    always_comb begin
        wide = '0;
        case (op)
            ALU_ADD: wide = {1'b0, a} + {1'b0, b};
            ALU_SUB: wide = {1'b0, a} + {1'b0, ~b} + ONE_W;
`ifdef PROC_LOGIC_OPS_EN
            ALU_AND: wide = {1'b0, a & b};
            ALU_XOR: wide = {1'b0, a ^ b};
`endif
            default: wide = '0;
        endcase
    end

    assign result    = wide[REG_WIDTH-1:0];
    assign carry_out = wide[REG_WIDTH];

endmodule

// File: rtl/multicycle_proc_core.sv
// Parametrised multicycle processor core. Fetches {opcode, rx, ry} from din
// in T0 and executes over a shared bus in 2 or 4 steps, pulsing done on the
// last one. Optional macro PROC_LOGIC_OPS_EN enables AND/XOR; without it
// those opcodes are reported as illegal like the reserved opcode.
module multicycle_proc_core
    import proc_pkg::*;
#(
    parameter int REG_WIDTH      = 16,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [REG_WIDTH-1:0] din,
    output logic [REG_WIDTH-1:0] bus,
    output logic                 done,
    output logic                 illegal,
    output logic                 zero,
    output logic                 carry
);

    localparam int NUM_REGS    = 2 ** REG_ADDR_WIDTH;
    localparam int INSTR_WIDTH = 3 + 2 * REG_ADDR_WIDTH;

    step_t                     step;
    logic [INSTR_WIDTH-1:0]    ir;
    logic [REG_WIDTH-1:0]      a_reg;
    logic [REG_WIDTH-1:0]      g_reg;
    logic [REG_WIDTH-1:0]      regs [NUM_REGS];

    logic [2:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rx;
    logic [REG_ADDR_WIDTH-1:0] ry;
    logic                      is_alu;
    logic                      reg_we;
    logic                      a_we;
    logic                      g_we;
    alu_op_t                   alu_op;
    logic [REG_WIDTH-1:0]      alu_result;
    logic                      alu_carry;

    assign opcode = ir[INSTR_WIDTH-1 -: 3];
    assign rx     = ir[2*REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
    assign ry     = ir[REG_ADDR_WIDTH-1:0];

`ifdef PROC_LOGIC_OPS_EN
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_XOR);
`else
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);
`endif

    // Map the instruction opcode onto the ALU operation select
    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_XOR:  alu_op = ALU_XOR;
            default: alu_op = ALU_ADD;
        endcase
    end

    proc_alu #(
        .REG_WIDTH(REG_WIDTH)
    ) u_alu (
        .a        (a_reg),
        .b        (bus),
        .op       (alu_op),
        .result   (alu_result),
        .carry_out(alu_carry)
    );

    // Decode step and opcode into bus source, write enables and status strobes
    always_comb begin
        bus     = '0;
        done    = 1'b0;
        illegal = 1'b0;
        reg_we  = 1'b0;
        a_we    = 1'b0;
        g_we    = 1'b0;
        case (step)
            T1: begin
                if (opcode == OP_MV) begin
                    bus    = regs[ry];
                    reg_we = 1'b1;
                    done   = 1'b1;
                end else if (opcode == OP_MVI) begin
                    bus    = din;
                    reg_we = 1'b1;
                    done   = 1'b1;
                end else if (opcode == OP_MVNZ) begin
                    bus    = regs[ry];
                    reg_we = ~zero;
                    done   = 1'b1;
                end else if (is_alu) begin
                    bus  = regs[rx];
                    a_we = 1'b1;
                end else begin
                    illegal = 1'b1;
                    done    = 1'b1;
                end
            end
            T2: begin
                if (is_alu) begin
                    bus  = regs[ry];
                    g_we = 1'b1;
                end
            end
            T3: begin
                if (is_alu) begin
                    bus    = g_reg;
                    reg_we = 1'b1;
                    done   = 1'b1;
                end
            end
            default: begin
                bus = '0;
            end
        endcase
    end

    // Step counter, instruction register, ALU operand/result and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step  <= T0;
            ir    <= '0;
            a_reg <= '0;
            g_reg <= '0;
            zero  <= 1'b1;
            carry <= 1'b0;
        end else begin
            if (done) begin
                step <= T0;
            end else begin
                case (step)
                    T0: if (run) step <= T1;
                    T1: step <= T2;
                    T2: step <= T3;
                    default: step <= T0;
                endcase
            end
            if (step == T0 && run) begin
                ir <= din[INSTR_WIDTH-1:0];
            end
            if (a_we) begin
                a_reg <= bus;
            end
            if (g_we) begin
                g_reg <= alu_result;
                zero  <= (alu_result == '0);
                carry <= alu_carry;
            end
        end
    end

    // Register file written from the bus at the end of the final step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[rx] <= bus;
        end
    end

endmodule

// File: tb/tb_multicycle_proc_core.sv
// Self-checking bench for multicycle_proc_core. A behavioural model of the
// register file and flags predicts bus/done/illegal/zero/carry for every
// cycle; a single compare process checks them on the falling edge.
module tb_multicycle_proc_core;

    localparam int W  = 16;
    localparam int AW = 3;

`ifdef PROC_LOGIC_OPS_EN
    localparam bit LOGIC_OPS = 1'b1;
`else
    localparam bit LOGIC_OPS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [W-1:0]  din;
    logic [W-1:0]  bus;
    logic          done;
    logic          illegal;
    logic          zero;
    logic          carry;

    logic          run32;
    logic [31:0]   din32;
    logic [31:0]   bus32;
    logic          done32;
    logic          illegal32;
    logic          zero32;
    logic          carry32;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  m_regs [8];
    bit            m_zero;
    bit            m_carry;

    bit            exp_valid = 1'b0;
    logic [W-1:0]  exp_bus;
    logic          exp_done;
    logic          exp_illegal;
    logic          exp_zero;
    logic          exp_carry;

    always #5 clk = ~clk;

    multicycle_proc_core #(.REG_WIDTH(W), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .run(run), .din(din), .bus(bus),
        .done(done), .illegal(illegal), .zero(zero), .carry(carry)
    );

    multicycle_proc_core #(.REG_WIDTH(32), .REG_ADDR_WIDTH(4)) dut32 (
        .clk(clk), .rst(rst), .run(run32), .din(din32), .bus(bus32),
        .done(done32), .illegal(illegal32), .zero(zero32), .carry(carry32)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of the DUT against the model's expectation
    always @(negedge clk) begin
        if (exp_valid) begin
            checkOutput("bus", 32'(bus), 32'(exp_bus));
            checkOutput("done", 32'(done), 32'(exp_done));
            checkOutput("illegal", 32'(illegal), 32'(exp_illegal));
            checkOutput("zero", 32'(zero), 32'(exp_zero));
            checkOutput("carry", 32'(carry), 32'(exp_carry));
        end
    end

    task automatic driveCycle(input logic r, input logic [W-1:0] d,
                              input logic [W-1:0] eb, input logic ed, input logic ei);
        @(posedge clk);
        #1;
        run         = r;
        din         = d;
        exp_bus     = eb;
        exp_done    = ed;
        exp_illegal = ei;
        exp_zero    = m_zero;
        exp_carry   = m_carry;
        exp_valid   = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            driveCycle(1'b0, W'($urandom), '0, 1'b0, 1'b0);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rx,
                                 input logic [2:0] ry, input logic [W-1:0] imm);
        logic [W-1:0] word;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        int unsigned  res;
        bit           alu_ok;
        word      = W'($urandom);
        word[8:0] = {op, rx, ry};
        driveCycle(1'b1, word, '0, 1'b0, 1'b0);
        av     = m_regs[rx];
        bv     = m_regs[ry];
        alu_ok = (op == 3'd2) || (op == 3'd3) ||
                 (LOGIC_OPS && (op == 3'd4 || op == 3'd5));
        if (op == 3'd0) begin
            driveCycle(1'($urandom), W'($urandom), bv, 1'b1, 1'b0);
            m_regs[rx] = bv;
        end else if (op == 3'd1) begin
            driveCycle(1'($urandom), imm, imm, 1'b1, 1'b0);
            m_regs[rx] = imm;
        end else if (op == 3'd6) begin
            driveCycle(1'($urandom), W'($urandom), bv, 1'b1, 1'b0);
            if (!m_zero) m_regs[rx] = bv;
        end else if (alu_ok) begin
            driveCycle(1'($urandom), W'($urandom), av, 1'b0, 1'b0);
            driveCycle(1'($urandom), W'($urandom), bv, 1'b0, 1'b0);
            case (op)
                3'd2: begin
                    res     = int'(av) + int'(bv);
                    m_carry = (res >= 32'h10000);
                end
                3'd3: begin
                    res     = (int'(av) - int'(bv)) & 32'hFFFF;
                    m_carry = (av >= bv);
                end
                3'd4: begin
                    res     = int'(av & bv);
                    m_carry = 1'b0;
                end
                default: begin
                    res     = int'(av ^ bv);
                    m_carry = 1'b0;
                end
            endcase
            res    = res & 32'hFFFF;
            m_zero = (res == 0);
            driveCycle(1'($urandom), W'($urandom), W'(res), 1'b1, 1'b0);
            m_regs[rx] = W'(res);
        end else begin
            driveCycle(1'($urandom), W'($urandom), '0, 1'b1, 1'b1);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_zero  = 1'b1;
        m_carry = 1'b0;
    endtask

    initial begin
        modelReset();
        rst   = 1'b1;
        run   = 1'b0;
        din   = '0;
        run32 = 1'b0;
        din32 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_bus", 32'(bus), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_illegal", 32'(illegal), 32'h0);
        checkOutput("reset_zero", 32'(zero), 32'h1);
        checkOutput("reset_carry", 32'(carry), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic moves
        applyStimulus(3'd1, 3'd0, 3'd0, 16'h0005);
        applyStimulus(3'd0, 3'd1, 3'd0, '0);
        checkOutput("pin_mv_r1", 32'(m_regs[1]), 32'h0005);

        // Add and subtract
        applyStimulus(3'd1, 3'd4, 3'd0, 16'h0005);
        applyStimulus(3'd1, 3'd5, 3'd0, 16'h0003);
        applyStimulus(3'd2, 3'd4, 3'd5, '0);
        checkOutput("pin_add_r4", 32'(m_regs[4]), 32'h0008);
        checkOutput("pin_add_carry", 32'(m_carry), 32'h0);
        applyStimulus(3'd3, 3'd4, 3'd5, '0);
        checkOutput("pin_sub_r4", 32'(m_regs[4]), 32'h0005);
        checkOutput("pin_sub_carry", 32'(m_carry), 32'h1);

        // Wrap-around and conditional move
        applyStimulus(3'd1, 3'd2, 3'd0, 16'hFFFF);
        applyStimulus(3'd1, 3'd3, 3'd0, 16'h0001);
        applyStimulus(3'd2, 3'd2, 3'd3, '0);
        checkOutput("pin_wrap_r2", 32'(m_regs[2]), 32'h0000);
        checkOutput("pin_wrap_zc", 32'({m_zero, m_carry}), 32'h3);
        applyStimulus(3'd6, 3'd6, 3'd2, '0);
        checkOutput("pin_mvnz_hold", 32'(m_regs[6]), 32'h0000);
        applyStimulus(3'd3, 3'd2, 3'd3, '0);
        checkOutput("pin_borrow_r2", 32'(m_regs[2]), 32'hFFFF);
        checkOutput("pin_borrow_zc", 32'({m_zero, m_carry}), 32'h0);
        applyStimulus(3'd6, 3'd6, 3'd2, '0);
        checkOutput("pin_mvnz_take", 32'(m_regs[6]), 32'hFFFF);

        // Reserved opcode, then same-register cases
        applyStimulus(3'd7, 3'd1, 3'd2, '0);
        applyStimulus(3'd0, 3'd3, 3'd3, '0);
        applyStimulus(3'd2, 3'd5, 3'd5, '0);
        checkOutput("pin_rxry_add", 32'(m_regs[5]), 32'h0006);

        // Logic ops (or illegal without the option)
        applyStimulus(3'd1, 3'd0, 3'd0, 16'h00F0);
        applyStimulus(3'd1, 3'd1, 3'd0, 16'h0FF0);
        applyStimulus(3'd4, 3'd0, 3'd1, '0);
        checkOutput("pin_and_r0", 32'(m_regs[0]), 32'h00F0);
        applyStimulus(3'd5, 3'd0, 3'd1, '0);
        checkOutput("pin_xor_r0", 32'(m_regs[0]), LOGIC_OPS ? 32'h0F00 : 32'h00F0);
        idle(2);

        // Reset during T2 of an ADD
        driveCycle(1'b1, {7'h0, 3'd2, 3'd4, 3'd5}, '0, 1'b0, 1'b0);
        driveCycle(1'b0, W'($urandom), m_regs[4], 1'b0, 1'b0);
        @(posedge clk);
        #1 exp_valid = 1'b0;
        run = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_bus", 32'(bus), 32'h0);
        checkOutput("midrst_done", 32'(done), 32'h0);
        checkOutput("midrst_zero", 32'(zero), 32'h1);
        checkOutput("midrst_carry", 32'(carry), 32'h0);
        modelReset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            applyStimulus(3'd0, 3'(r), 3'(r), '0);
        end

        // Randomised instruction stream
        for (int n = 0; n < 300; n++) begin
            applyStimulus(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom),
                          W'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        // Wide build: 32-bit datapath, 16 registers
        @(posedge clk);
        #1 exp_valid = 1'b0;
        run   = 1'b0;
        run32 = 1'b1;
        din32 = {21'h0, 3'b001, 4'hF, 4'h0};
        @(posedge clk);
        #1 run32 = 1'b0;
        din32 = 32'hDEADBEEF;
        @(negedge clk);
        checkOutput("w32_mvi_bus", bus32, 32'hDEADBEEF);
        checkOutput("w32_mvi_done", 32'(done32), 32'h1);
        @(posedge clk);
        #1 run32 = 1'b1;
        din32 = {21'h0, 3'b000, 4'h0, 4'hF};
        @(negedge clk);
        checkOutput("w32_t0_bus", bus32, 32'h0);
        @(posedge clk);
        #1 run32 = 1'b0;
        din32 = 32'h12345678;
        @(negedge clk);
        checkOutput("w32_mv_bus", bus32, 32'hDEADBEEF);
        checkOutput("w32_mv_done", 32'(done32), 32'h1);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
